// File: rtl/buffer_pkg.sv
// Shared control types for the capture buffer's write and read sides.
package buffer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10
  } state_t;

  // Address width for a buffer of the given depth; a 1-entry buffer still needs one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reader_skid_fifo.sv
// Two-entry output queue for the drain reader: data word plus last flag.
module reader_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = slot[rd_ptr];
  assign do_pop  = pop && !empty;
  // When full, a push is only legal alongside a pop: the write lands in the slot being vacated.
  assign do_push = push && (!full || do_pop);

  // NOTE: the two slots are reset so the head (and thus out_data) reads zero after reset;
  // at two entries this costs nothing, unlike resetting a real RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (do_push) begin
        slot[wr_ptr] <= wdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/buffer_drain_reader.sv
// Drains every entry of the capture buffer in address order onto a valid/ready stream.
module buffer_drain_reader
  import buffer_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t         state;
  logic           inflight;
  logic           inflight_last;
  logic           reads_left;
  logic           xfer;
  logic           q_full;
  logic           q_empty;
  logic [1:0]     q_count;
  logic [WIDTH:0] q_head;
  logic [2:0]     pending;

  reader_skid_fifo #(.W(WIDTH + 1)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (xfer),
    .wdata ({inflight_last, rd_data}),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  assign out_valid = !q_empty;
  assign out_data  = q_head[WIDTH-1:0];
  assign out_last  = q_head[WIDTH];
  assign xfer      = out_valid && out_ready;

  // Credit check: a new read is allowed only if queue + in-flight, after this
  // cycle's transfer, leaves room for the word it will return.
  assign pending = {1'b0, q_count} + {2'b00, inflight};
  assign rd_en   = (state == ACTIVE) && reads_left &&
                   (xfer ? !(q_full && inflight) : (pending < 3'd2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      reads_left    <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        inflight_last <= (rd_addr == LAST_ADDR);
        if (rd_addr == LAST_ADDR) reads_left <= 1'b0;
        else                      rd_addr    <= rd_addr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACTIVE;
            busy       <= 1'b1;
            reads_left <= 1'b1;
            rd_addr    <= '0;
          end
        end
        ACTIVE: begin
          if (xfer && out_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          rd_addr <= '0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          rd_addr    <= '0;
          reads_left <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_drain_reader.sv
// Randomised and directed bench for buffer_drain_reader with a stream-level reference model.
module tb_buffer_drain_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: DEPTH=4
  logic             start = 1'b0, out_ready = 1'b0;
  logic             busy, rd_en, out_valid, out_last, done;
  logic [1:0]       rd_addr;
  logic [WIDTH-1:0] rd_data = '0, out_data;
  logic [WIDTH-1:0] mem_a [DEPTH];

  // DUT B: DEPTH=1
  logic             start_b = 1'b0, ready_b = 1'b0;
  logic             busy_b, rd_en_b, valid_b, last_b, done_b;
  logic [0:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_b = '0, data_b;
  logic [WIDTH-1:0] mem_b = 8'h5C;

  buffer_drain_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .done(done)
  );

  buffer_drain_reader #(.WIDTH(WIDTH), .DEPTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .rd_en(rd_en_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_data(data_b), .out_last(last_b), .done(done_b)
  );

  // External buffer arrays with 1-cycle read latency
  always @(posedge clk) if (rd_en) rd_data <= mem_a[rd_addr];
  always @(posedge clk) if (rd_en_b) rd_data_b <= mem_b;

  int total = 0;
  int bad = 0;

  // Observation of DUT A
  logic [WIDTH:0]   xq [$];
  int               xcyc [$];
  int               rdcyc [$];
  int               rdaddr [$];
  int               doneq [$];
  int               outstanding = 0;
  int               occ_err = 0;
  int               stall_err = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
        stall_err++;
      if (rd_en) begin
        rdcyc.push_back(cyc);
        rdaddr.push_back(int'(rd_addr));
        outstanding++;
      end
      if (out_valid && out_ready) begin
        xq.push_back({out_last, out_data});
        xcyc.push_back(cyc);
        outstanding--;
      end
      if (outstanding > 2) occ_err++;
      if (done) doneq.push_back(cyc);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Observation of DUT B
  logic [WIDTH:0] xq_b [$];
  int             xcyc_b [$];
  int             doneq_b [$];
  int             rdcount_b = 0;
  int             addr_b_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_addr_b !== 1'b0) addr_b_err++;
      if (rd_en_b) rdcount_b++;
      if (valid_b && ready_b) begin
        xq_b.push_back({last_b, data_b});
        xcyc_b.push_back(cyc);
      end
      if (done_b) doneq_b.push_back(cyc);
    end
  end

  // Reference model: the stream is the buffer in address order, last on the final entry.
  function automatic logic [WIDTH:0] exp_word(input int i);
    return {(i == DEPTH - 1), mem_a[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_mon();
    xq.delete(); xcyc.delete(); rdcyc.delete(); rdaddr.delete(); doneq.delete();
    occ_err = 0;
    stall_err = 0;
  endtask

  task automatic load_plan_buffer();
    for (int i = 0; i < DEPTH; i++) mem_a[i] = 8'hA0 + 8'(i);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rd_en !== 1'b0)     begin bad++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_last !== 1'b0)  begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (rd_addr !== 2'd0)   begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    total++; if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
      bad++; $display("FAIL reset_dut_b got busy=%b valid=%b want 0/0", busy_b, valid_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int t0;
    load_plan_buffer();
    clear_mon();
    out_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    wait_cyc(t0 + 7);
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL basic_done_cycle got done=%b busy=%b want 1/1", done, busy);
    end
    wait_cyc(t0 + 8);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_low got=%b want=0", busy); end
    total++; if (rdcyc.size() < 1 || rdcyc[0] != t0 + 1) begin
      bad++; $display("FAIL basic_first_rd got=%0d want=%0d", rdcyc.size() ? rdcyc[0] - t0 : -1, 1);
    end
    total++; if (xq.size() != DEPTH) begin bad++; $display("FAIL basic_count got=%0d want=%0d", xq.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < xq.size(); i++) begin
      total++; if (xq[i] !== exp_word(i) || xcyc[i] != t0 + 3 + i) begin
        bad++; $display("FAIL basic_word%0d got=%h@%0d want=%h@%0d", i, xq[i], xcyc[i] - t0, exp_word(i), 3 + i);
      end
    end
    total++; if (doneq.size() != 1 || doneq[0] != t0 + 7) begin
      bad++; $display("FAIL basic_done got n=%0d want n=1 at +7", doneq.size());
    end
  endtask

  task automatic test_backpressure();
    int t0;
    load_plan_buffer();
    clear_mon();
    out_ready = 1'b0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    wait_cyc(t0 + 8);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      bad++; $display("FAIL bp_hold got valid=%b data=%h want 1/a0", out_valid, out_data);
    end
    wait_cyc(t0 + 11);
    total++; if (rdcyc.size() != 2 || rdaddr[0] != 0 || rdaddr[1] != 1) begin
      bad++; $display("FAIL bp_reads got n=%0d want n=2 addr 0,1", rdcyc.size());
    end
    out_ready = 1'b1;
    wait_cyc(t0 + 20);
    total++; if (xq.size() != DEPTH) begin bad++; $display("FAIL bp_count got=%0d want=%0d", xq.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < xq.size(); i++) begin
      total++; if (xq[i] !== exp_word(i) || xcyc[i] != t0 + 11 + i) begin
        bad++; $display("FAIL bp_word%0d got=%h@%0d want=%h@%0d", i, xq[i], xcyc[i] - t0, exp_word(i), 11 + i);
      end
    end
    total++; if (stall_err != 0 || occ_err != 0) begin
      bad++; $display("FAIL bp_stable got stall_err=%0d occ_err=%0d want 0/0", stall_err, occ_err);
    end
    total++; if (doneq.size() != 1 || doneq[0] != t0 + 15) begin
      bad++; $display("FAIL bp_done got n=%0d want n=1 at +15", doneq.size());
    end
  endtask

  task automatic test_toggle();
    int t0;
    load_plan_buffer();
    clear_mon();
    out_ready = 1'b0;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      out_ready = (cyc >= t0 + 3) && (((cyc - t0 - 3) % 2) == 0);
      tick();
    end
    out_ready = 1'b1;
    total++; if (xq.size() != DEPTH) begin bad++; $display("FAIL tog_count got=%0d want=%0d", xq.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < xq.size(); i++) begin
      total++; if (xq[i] !== exp_word(i) || xcyc[i] != t0 + 3 + 2 * i) begin
        bad++; $display("FAIL tog_word%0d got=%h@%0d want=%h@%0d", i, xq[i], xcyc[i] - t0, exp_word(i), 3 + 2 * i);
      end
    end
    total++; if (occ_err != 0 || stall_err != 0) begin
      bad++; $display("FAIL tog_occupancy got occ_err=%0d stall_err=%0d want 0/0", occ_err, stall_err);
    end
    total++; if (doneq.size() != 1 || xcyc.size() != DEPTH || doneq[0] != xcyc[DEPTH-1] + 1) begin
      bad++; $display("FAIL tog_done got n=%0d want one pulse after last transfer", doneq.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    load_plan_buffer();
    clear_mon();
    out_ready = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 20; k++) begin
      start = (k == 0) || (k == 4) || (k == 7) || (k == 8);
      tick();
    end
    start = 1'b0;
    total++; if (xq.size() != 2 * DEPTH) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", xq.size(), 2 * DEPTH); end
    for (int i = 0; i < 2 * DEPTH && i < xq.size(); i++) begin
      int want_c;
      want_c = (i < DEPTH) ? t0 + 3 + i : t0 + 11 + (i - DEPTH);
      total++; if (xq[i] !== exp_word(i % DEPTH) || xcyc[i] != want_c) begin
        bad++; $display("FAIL b2b_word%0d got=%h@%0d want=%h@%0d", i, xq[i], xcyc[i] - t0, exp_word(i % DEPTH), want_c - t0);
      end
    end
    total++; if (doneq.size() != 2 || doneq[0] != t0 + 7 || doneq[1] != t0 + 15) begin
      bad++; $display("FAIL b2b_done got n=%0d want n=2 at +7,+15", doneq.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    for (int i = 0; i < DEPTH; i++) mem_a[i] = 8'($urandom);
    clear_mon();
    out_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    wait_cyc(t0 + 5);
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs got valid=%b rd_en=%b busy=%b done=%b want 0", out_valid, rd_en, busy, done);
    end
    total++; if (xq.size() != 2 || xq[0] !== exp_word(0) || xq[1] !== exp_word(1)) begin
      bad++; $display("FAIL rstmid_pre got n=%0d want 2 words", xq.size());
    end
    tick();
    tick();
    rst_n = 1'b1;
    clear_mon();
    repeat (5) tick();
    total++; if (xq.size() != 0 || rdcyc.size() != 0 || doneq.size() != 0) begin
      bad++; $display("FAIL rstmid_stale got xfer=%0d rd=%0d done=%0d want 0", xq.size(), rdcyc.size(), doneq.size());
    end
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    wait_cyc(t0 + 10);
    total++; if (xq.size() != DEPTH) begin bad++; $display("FAIL rstmid_count got=%0d want=%0d", xq.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < xq.size(); i++) begin
      total++; if (xq[i] !== exp_word(i) || xcyc[i] != t0 + 3 + i) begin
        bad++; $display("FAIL rstmid_word%0d got=%h@%0d want=%h@%0d", i, xq[i], xcyc[i] - t0, exp_word(i), 3 + i);
      end
    end
    total++; if (doneq.size() != 1 || doneq[0] != t0 + 7) begin
      bad++; $display("FAIL rstmid_done got n=%0d want n=1 at +7", doneq.size());
    end
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 10; iter++) begin
      int t0;
      int bias;
      for (int i = 0; i < DEPTH; i++) mem_a[i] = 8'($urandom);
      bias = int'($urandom_range(1, 3));
      clear_mon();
      start = 1'b1;
      t0 = cyc;
      tick();
      for (int k = 0; k < 80 && doneq.size() == 0; k++) begin
        start     = ($urandom_range(0, 3) == 0);
        out_ready = ($urandom_range(0, 3) < bias);
        tick();
      end
      start = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      total++; if (xq.size() != DEPTH) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", iter, xq.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < xq.size(); i++) begin
        total++; if (xq[i] !== exp_word(i)) begin
          bad++; $display("FAIL rnd%0d_word%0d got=%h want=%h", iter, i, xq[i], exp_word(i));
        end
      end
      total++; if (stall_err != 0 || occ_err != 0) begin
        bad++; $display("FAIL rnd%0d_flow got stall_err=%0d occ_err=%0d want 0/0", iter, stall_err, occ_err);
      end
      total++; if (doneq.size() != 1 || xcyc.size() == 0 || doneq[0] != xcyc[xcyc.size()-1] + 1) begin
        bad++; $display("FAIL rnd%0d_done got n=%0d want one pulse after last transfer", iter, doneq.size());
      end
      total++; if (busy !== 1'b0 || rdcyc.size() != DEPTH) begin
        bad++; $display("FAIL rnd%0d_end got busy=%b reads=%0d want 0/%0d", iter, busy, rdcyc.size(), DEPTH);
      end
    end
  endtask

  task automatic test_depth1();
    int t0;
    xq_b.delete(); xcyc_b.delete(); doneq_b.delete();
    rdcount_b = 0;
    addr_b_err = 0;
    ready_b = 1'b1;
    start_b = 1'b1;
    t0 = cyc;
    tick();
    start_b = 1'b0;
    wait_cyc(t0 + 7);
    total++; if (xq_b.size() != 1 || xq_b[0] !== {1'b1, 8'h5C} || xcyc_b[0] != t0 + 3) begin
      bad++; $display("FAIL d1_word got n=%0d word=%h want 1 x 15c at +3", xq_b.size(), xq_b.size() ? xq_b[0] : 9'h0);
    end
    total++; if (doneq_b.size() != 1 || doneq_b[0] != t0 + 4) begin
      bad++; $display("FAIL d1_done got n=%0d want n=1 at +4", doneq_b.size());
    end
    total++; if (addr_b_err != 0 || rdcount_b != 1) begin
      bad++; $display("FAIL d1_addr got addr_err=%0d reads=%0d want 0/1", addr_b_err, rdcount_b);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    tick();
    test_backpressure();
    tick();
    test_toggle();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid();
    tick();
    test_random();
    tick();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffer_drain_reader.md
Name: buffer_drain_reader

Overview:
Reader side of the team's parameterised capture buffer. On a start pulse it reads all DEPTH entries of an external WIDTH x DEPTH buffer array, which has 1-cycle read latency. It streams the words out in address order over a valid/ready interface, marks the final word with last, then pulses done. It uses the same IDLE/ACTIVE/DONE control enum as the buffer's write side.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, number of buffer entries; legal range >= 1
ADDR_W, max(1, $clog2(DEPTH)), read address width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to drain the buffer; sampled only in IDLE
busy  output  1  high in ACTIVE and DONE
rd_en  output  1  buffer read strobe
rd_addr  output  ADDR_W  buffer read address; rd_data is valid the cycle after rd_en
rd_data  input  WIDTH  buffer read data
out_valid  output  1  out_data/out_last valid
out_ready  input  1  downstream accept; transfer occurs when out_valid && out_ready
out_data  output  WIDTH  streamed word
out_last  output  1  high with the word read from address DEPTH-1
done  output  1  one-cycle pulse after the last transfer

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. All state resets on rst_n=0.
- Reset values: state=IDLE; busy, rd_en, out_valid, out_last, done = 0; rd_addr=0; out_data=0; output queue empty; in-flight flag = 0.
- States (state_t): IDLE=2'b00, ACTIVE=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and returns to IDLE on the next edge.
- IDLE -> ACTIVE: on start=1. start in ACTIVE or DONE is ignored and is not queued.
- ACTIVE -> DONE: on the transfer of the out_last word.
- DONE -> IDLE: unconditionally after one cycle; done=1 only in DONE.
- Read issue:
  - rd_addr counts 0..DEPTH-1 and advances by 1 per rd_en. No reads are issued after address DEPTH-1.
  - Output buffering is a 2-entry queue.
  - rd_en=1 in ACTIVE iff reads remain and (queue occupancy + in-flight read - transfer this cycle) < 2. The queue therefore never overflows and never drops rd_data.
- Capture: the in-flight flag is set on rd_en and cleared the next cycle, when rd_data is written into the queue tail.
- Output: out_data/out_last come from the queue head; out_valid = queue not empty. While out_valid && !out_ready, out_data and out_last hold stable.
- Latency:
  - start at cycle t: ACTIVE and rd_en(addr 0) at t+1; rd_data at t+2; out_valid at t+3.
  - With out_ready held high: one word per cycle, transfers at t+3..t+2+DEPTH, done at t+3+DEPTH, IDLE at t+4+DEPTH.
- Backpressure: with out_ready=0, at most 2 words are buffered plus 0 in flight. Reads resume the cycle after a slot frees.
- DEPTH=1: the single word carries out_last=1; rd_addr stays 0.
- Simultaneous capture and transfer with queue full: legal. Occupancy stays 2 and ordering is preserved.
- rd_addr returns to 0 on entry to IDLE.
- Reset mid-operation: queue flushed, in-flight read discarded, outputs to reset values immediately (async). No done pulse.
- Back-to-back: start asserted in the DONE cycle is ignored; start in the following IDLE cycle is accepted.

Decomposition:
- Shared package buffer_pkg: state_t enum (logic [1:0], IDLE/ACTIVE/DONE). The write side imports the same package.
- Sub-module reader_skid_fifo: 2-entry WIDTH+1 bit queue (data plus last flag). Signals: push, pop, full, empty, count, head. Pop-and-push when full is allowed.
- Top level holds the FSM, the read address counter, the in-flight flag and the credit check.

Test Plan:
- WIDTH=8, DEPTH=4, buffer = A0,A1,A2,A3; start at cycle 0; out_ready=1 -> out_valid cycles 3..6, data A0..A3, out_last only with A3, done=1 at cycle 7, busy low at cycle 8.
- Same buffer, out_ready=0 cycles 0..10 then 1 -> rd_en issued exactly twice (addr 0,1) before cycle 11. A0 held stable on out_data. Full ordered stream A0..A3 follows, with no duplicates or drops.
- out_ready toggling 1,0,1,0 from cycle 3 -> 4 transfers in order A0..A3. Queue occupancy never exceeds 2. done follows the A3 transfer by one cycle.
- start re-pulsed in ACTIVE at cycle 4 and in the DONE cycle -> ignored: exactly 4 transfers and one done pulse. start one cycle after DONE -> a second full A0..A3 stream.
- rst_n=0 at cycle 5 (async, mid-edge) after 2 transfers -> out_valid, rd_en, busy low immediately. After release, no stale words appear and a new start yields A0..A3.
- DEPTH=1, buffer = 5C; start -> single transfer of 5C with out_last=1 at cycle 3; done at cycle 4; rd_addr stays 0.
